// File: rtl/ram_load_arbiter.sv
// Arbitrates the single data-RAM port between the running CPU and a host loader.
// A host load freezes the CPU, drains its last write, streams a burst, then resets the CPU.
module ram_load_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RST_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wen,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  output logic              cpu_rst_n,
  input  logic              h_start,
  input  logic [ADDR_W-1:0] h_base,
  input  logic [ADDR_W:0]   h_count,
  input  logic              h_valid,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ready,
  output logic              h_busy,
  output logic              h_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned REM_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HOST    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e             state;
  state_e             state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [REM_W-1:0]   rem_q;
  logic [REM_W-1:0]   rem_d;
  logic [CNT_W-1:0]   rcnt_q;
  logic [CNT_W-1:0]   rcnt_d;
  logic               accept;
  logic               run_d;
  logic               rst_n_d;
  logic               ready_d;
  logic               busy_d;
  logic               done_d;

  assign cpu_rdata = ram_rdata;
  assign accept    = (state == ST_HOST) && h_valid && h_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU: begin
        if (h_start) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_nxt = (rem_q != '0) ? ST_HOST : ST_RELEASE;
      end
      ST_HOST: begin
        if (accept && (rem_q == REM_W'(1))) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rcnt_q == CNT_W'(RST_CYC - 1)) state_nxt = ST_CPU;
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  // Load address, remaining count and CPU-reset counter
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    rcnt_d = '0;
    if ((state == ST_CPU) && h_start) begin
      addr_d = h_base;
      rem_d  = h_count;
    end else if (accept) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - REM_W'(1);
    end
    if (state == ST_RELEASE) rcnt_d = rcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      rcnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Output logic: RAM port mux plus next values of the registered controls
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_wen   = cpu_wen;
    case (state)
      ST_HOST: begin
        ram_addr  = addr_q;
        ram_wdata = h_wdata;
        ram_wen   = h_valid & h_ready;
      end
      ST_RELEASE: begin
        ram_addr  = addr_q;
        ram_wdata = h_wdata;
        ram_wen   = 1'b0;
      end
      default: ;
    endcase
    run_d   = (state_nxt == ST_CPU);
    rst_n_d = (state_nxt != ST_RELEASE);
    ready_d = (state_nxt == ST_HOST);
    busy_d  = (state_nxt != ST_CPU);
    done_d  = (state_nxt == ST_RELEASE) && (state != ST_RELEASE);
  end

  // Registered control outputs; reset holds the CPU stopped and in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_run   <= 1'b0;
      cpu_rst_n <= 1'b0;
      h_ready   <= 1'b0;
      h_busy    <= 1'b0;
      h_done    <= 1'b0;
    end else begin
      cpu_run   <= run_d;
      cpu_rst_n <= rst_n_d;
      h_ready   <= ready_d;
      h_busy    <= busy_d;
      h_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Randomized bench for ram_load_arbiter: a behavioural RAM plus a reference memory image
// built from the load rules, compared after each load along with handshake timing.
module tb_ram_load_arbiter;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RST_CYC = 2;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wen;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_run;
  logic              cpu_rst_n;
  logic              h_start;
  logic [ADDR_W-1:0] h_base;
  logic [ADDR_W:0]   h_count;
  logic              h_valid;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ready;
  logic              h_busy;
  logic              h_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;
  int wen_cnt, done_cnt, rstlow_cnt;

  ram_load_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_rdata(cpu_rdata),
    .cpu_run(cpu_run), .cpu_rst_n(cpu_rst_n),
    .h_start(h_start), .h_base(h_base), .h_count(h_count), .h_valid(h_valid),
    .h_wdata(h_wdata), .h_ready(h_ready), .h_busy(h_busy), .h_done(h_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM behind the arbiter
  always @(posedge clk) if (ram_wen) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample this cycle's outputs after inputs settle, then advance one cycle
  task automatic cyc();
    #1;
    if (ram_wen) wen_cnt++;
    if (h_done) done_cnt++;
    if (!cpu_rst_n) rstlow_cnt++;
    @(negedge clk);
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // vmode: 0 valid every cycle, 1 valid every other cycle, 2 random valid
  task automatic do_load(input logic [ADDR_W-1:0] base, input int cnt, input int vmode,
                         input bit col, input int abort_at, input bit seq);
    int idx, t, n, rdy_bad;
    logic v;
    logic [ADDR_W-1:0] a;
    wen_cnt = 0; done_cnt = 0; rstlow_cnt = 0; rdy_bad = 0;
    check("pre_run", 32'(cpu_run), 32'd1);
    check("pre_busy", 32'(h_busy), 32'd0);
    h_start = 1'b1; h_base = base; h_count = (ADDR_W+1)'(cnt);
    if (col) begin
      cpu_addr = 13'h020; cpu_wdata = 32'h55; cpu_wen = 1'b1; ref_mem[13'h020] = 32'h55;
    end
    cyc();
    h_start = 1'b0; h_base = ADDR_W'($urandom); h_count = (ADDR_W+1)'($urandom);
    check("drain_run", 32'(cpu_run), 32'd0);
    check("drain_busy", 32'(h_busy), 32'd1);
    check("drain_rdy", 32'(h_ready), 32'd0);
    if (col) begin
      cpu_addr = 13'h021; cpu_wdata = 32'h66; cpu_wen = 1'b1; ref_mem[13'h021] = 32'h66;
    end else cpu_wen = 1'b0;
    cyc();
    check(cnt == 0 ? "rdy_zero" : "rdy_lat", 32'(h_ready), cnt == 0 ? 32'd0 : 32'd1);
    if (col) begin
      cpu_addr = 13'h022; cpu_wdata = 32'h77; cpu_wen = 1'b1;
    end
    idx = 0; t = 0; a = base;
    while (idx < cnt && t < 2000 && !(abort_at >= 0 && idx == abort_at)) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      h_valid = v;
      h_wdata = seq ? 32'hA0 + 32'(idx) : $urandom;
      h_start = 1'($urandom_range(0, 1));
      if (h_ready !== 1'b1) rdy_bad++;
      if (v) begin
        ref_mem[a] = h_wdata;
        a = a + ADDR_W'(1);
        idx++;
      end
      cyc();
      t++;
    end
    check("host_rdy", 32'(rdy_bad), 32'd0);
    check("host_words", 32'(idx), abort_at >= 0 ? 32'(abort_at) : 32'(cnt));
    h_valid = 1'b0; h_start = 1'b0;
    if (abort_at >= 0) return;
    check("rdy_drop", 32'(h_ready), 32'd0);
    n = 1;
    while (!cpu_run && n < 50) begin
      cyc();
      n++;
    end
    cpu_wen = 1'b0;
    check("rel_lat", 32'(n), 32'(RST_CYC + 1));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("rst_low", 32'(rstlow_cnt), 32'(RST_CYC));
    check("wen_count", 32'(wen_cnt), 32'(cnt + (col ? 2 : 0)));
    check("rst_n_back", 32'(cpu_rst_n), 32'd1);
    check("busy_back", 32'(h_busy), 32'd0);
    check("mem_image", 32'(mem_diff()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b0; cpu_addr = 13'h010; cpu_wdata = 32'h11; cpu_wen = 1'b1;
    h_start = 1'b0; h_base = '0; h_count = '0; h_valid = 1'b0; h_wdata = '0;
    ref_mem[13'h010] = 32'h11;
    @(negedge clk);
    #1;
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_busy", 32'(h_busy), 32'd0);
    check("rst_ready", 32'(h_ready), 32'd0);
    check("rst_done", 32'(h_done), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'h010);
    check("rst_ram_wen", 32'(ram_wen), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1; cpu_wen = 1'b0;
    @(negedge clk);
    #1;
    check("run_after_rst", 32'(cpu_run), 32'd1);
    check("rst_n_after_rst", 32'(cpu_rst_n), 32'd1);
    check("cpu_rdata", cpu_rdata, 32'h11);
    @(negedge clk);

    do_load(13'h100, 4, 0, 1'b0, -1, 1'b1);
    check("mem_100", mem[13'h100], 32'hA0);
    check("mem_103", mem[13'h103], 32'hA3);

    do_load(13'h1FFE, 3, 2, 1'b0, -1, 1'b0);
    check("wrap_0000", 32'(mem[13'h0000] === ref_mem[13'h0000]), 32'd1);

    do_load(13'h0400, 0, 0, 1'b0, -1, 1'b0);

    do_load(13'h0500, 5, 1, 1'b1, -1, 1'b0);
    check("col_20", mem[13'h020], 32'h55);
    check("col_22_untouched", mem[13'h022], 32'h0);

    do_load(13'h0300, 5, 0, 1'b0, 2, 1'b0);
    reset = 1'b0; h_valid = 1'b1; h_wdata = 32'hDEAD_BEEF; cpu_wen = 1'b0;
    #1;
    check("abort_wen", 32'(ram_wen), 32'd0);
    check("abort_rdy", 32'(h_ready), 32'd0);
    check("abort_run", 32'(cpu_run), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1; h_valid = 1'b0;
    @(negedge clk);
    check("abort_recover", 32'(cpu_run), 32'd1);
    check("abort_image", 32'(mem_diff()), 32'd0);
    do_load(13'h0200, 2, 0, 1'b0, -1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      do_load(ADDR_W'($urandom), int'($urandom_range(0, 12)), 2, 1'b0, -1, 1'b0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
